// File: rtl/medfilt_axis_packer.sv
// Output stage for the 3x3 median filter: absorbs the filter's
// non-backpressured pixel stream in a small FIFO and re-emits it as
// AXI4-Stream video with SOF (tuser) and EOL (tlast) rebuilt from local
// frame counters. Also provides an almost-full throttle hint and a sticky
// overflow flag.
module medfilt_axis_packer #(
   parameter int DATA_WIDTH   = 8,
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 512,
   parameter int FIFO_DEPTH   = 16,
   parameter int AFULL_MARGIN = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   input  logic [DATA_WIDTH-1:0]             in_data,
   output logic                              in_afull,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic [DATA_WIDTH-1:0]             m_axis_tdata,
   output logic                              m_axis_tuser,
   output logic                              m_axis_tlast,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              overflow,
   input  logic                              clear_err,
   output logic                              frame_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int HW = $clog2(FRAME_WIDTH);
   localparam int VW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

   localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LVL_AFULL = LW'(FIFO_DEPTH - AFULL_MARGIN);
   localparam logic [HW-1:0] H_LAST    = HW'(FRAME_WIDTH - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(FRAME_HEIGHT - 1);

   // FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q, level_d;
   logic                  afull_q, afull_d;

   // Frame position of the next pixel to be loaded into the output register
   logic [HW-1:0]         hcnt_q, hcnt_d;
   logic [VW-1:0]         vcnt_q, vcnt_d;

   // Output register and status
   logic                  tvalid_q, tvalid_d;
   logic [DATA_WIDTH-1:0] tdata_q;
   logic                  tuser_q, tlast_q;
   logic                  eof_q;          // beat in output register ends the frame
   logic                  ovf_q, ovf_d;
   logic                  fdone_q, fdone_d;

   logic full, empty, push, drop, load;

   // Fullness is judged on the current level, so a same-cycle pop never
   // makes room for an incoming pixel.
   always_comb begin
      full  = (level_q == LVL_FULL);
      empty = (level_q == '0);
      push  = in_valid && !full;
      drop  = in_valid && full;
      load  = !empty && (!tvalid_q || m_axis_tready);
   end

   // Next-state for occupancy, almost-full, counters, handshake and flags
   always_comb begin
      level_d = level_q;
      case ({push, load})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      afull_d = (level_d >= LVL_AFULL);

      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (load) begin
         if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
         end else begin
            hcnt_d = hcnt_q + HW'(1);
         end
      end

      if (load)
         tvalid_d = 1'b1;
      else if (m_axis_tready)
         tvalid_d = 1'b0;
      else
         tvalid_d = tvalid_q;

      // A drop in the same cycle as clear_err wins, keeping the error visible
      if (drop)
         ovf_d = 1'b1;
      else if (clear_err)
         ovf_d = 1'b0;
      else
         ovf_d = ovf_q;

      fdone_d = tvalid_q && m_axis_tready && eof_q;
   end

   // FIFO storage write; contents need no reset since pointers gate reads
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= in_data;
   end

   // Pointers, level and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         afull_q  <= 1'b0;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         ovf_q    <= 1'b0;
         fdone_q  <= 1'b0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (load)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
         afull_q <= afull_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         ovf_q   <= ovf_d;
         fdone_q <= fdone_d;
      end
   end

   // Output register: loads the FIFO head with its frame markers; holds under stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tuser_q  <= 1'b0;
         tlast_q  <= 1'b0;
         eof_q    <= 1'b0;
      end else begin
         tvalid_q <= tvalid_d;
         if (load) begin
            tdata_q <= mem_q[rd_ptr_q];
            tuser_q <= (hcnt_q == '0) && (vcnt_q == '0);
            tlast_q <= (hcnt_q == H_LAST);
            eof_q   <= (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
         end
      end
   end

   assign in_afull      = afull_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tlast  = tlast_q;
   assign fifo_level    = level_q;
   assign overflow      = ovf_q;
   assign frame_done    = fdone_q;

endmodule
